wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the pipeline writeback
// stage and a multi-cycle unit (MDU). The pipeline normally has priority. One
// MDU result can be parked in a hold register until the port is free.
//
// If the parked result loses the port STARVE_LIMIT times in a row, the arbiter
// stalls the pipe for one cycle and writes the parked result.
//
// If the pipe writes the same non-zero register as the parked result, the pipe
// write is the younger one. In that case the parked result is dropped.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active low
//   pipe_wb_en     pipeline requests a register-file write
//   pipe_wb_addr   pipeline destination register
//   pipe_wb_data   pipeline write data
//   mdu_valid      MDU offers a result
//   mdu_addr       MDU destination register
//   mdu_data       MDU result data
//   mdu_ready      arbiter accepts the MDU result this cycle
//   pipe_stall     upstream must hold its writeback item this cycle
//   rf_we          registered register-file write enable
//   rf_waddr       registered register-file write address
//   rf_wdata       registered register-file write data
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wb_en,
    input  logic [4:0]  pipe_wb_addr,
    input  logic [31:0] pipe_wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q;
    logic [4:0]  holdAddr_q;
    logic [31:0] holdData_q;
    logic [3:0]  waitCnt_q;
    logic [3:0]  waitCnt_d;
    logic        pipeHitsHold;

    // Both handshake outputs are forced low while reset is held.
    assign mdu_ready  = rst && (state_q == IDLE);
    assign pipe_stall = rst && (state_q == FORCE);

    assign waitCnt_d = waitCnt_q + 4'd1;

    // Register 0 is never written, so a pipe write to x0 cannot overwrite the
    // parked result.
    assign pipeHitsHold = (pipe_wb_addr == holdAddr_q) && (pipe_wb_addr != 5'd0);

    // Arbitration FSM. rf_we defaults to 0 each cycle.
    // rf_waddr and rf_wdata keep their old values unless a write is granted.
    // A granted write to x0 still updates the address and data, but rf_we
    // stays low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            holdAddr_q <= 5'd0;
            holdData_q <= 32'd0;
            waitCnt_q  <= 4'd0;
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= 32'd0;
        end else begin
            rf_we <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pipe_wb_en) begin
                        rf_we    <= |pipe_wb_addr;
                        rf_waddr <= pipe_wb_addr;
                        rf_wdata <= pipe_wb_data;
                    end
                    if (mdu_valid) begin
                        holdAddr_q <= mdu_addr;
                        holdData_q <= mdu_data;
                        waitCnt_q  <= 4'd0;
                        state_q    <= PEND;
                    end
                end
                PEND: begin
                    if (!pipe_wb_en) begin
                        rf_we      <= |holdAddr_q;
                        rf_waddr   <= holdAddr_q;
                        rf_wdata   <= holdData_q;
                        holdAddr_q <= 5'd0;
                        holdData_q <= 32'd0;
                        waitCnt_q  <= 4'd0;
                        state_q    <= IDLE;
                    end else begin
                        rf_we    <= |pipe_wb_addr;
                        rf_waddr <= pipe_wb_addr;
                        rf_wdata <= pipe_wb_data;
                        if (pipeHitsHold) begin
                            holdAddr_q <= 5'd0;
                            holdData_q <= 32'd0;
                            waitCnt_q  <= 4'd0;
                            state_q    <= IDLE;
                        end else begin
                            waitCnt_q <= waitCnt_d;
                            if (waitCnt_d == LIMIT) begin
                                state_q <= FORCE;
                            end
                        end
                    end
                end
                FORCE: begin
                    rf_we      <= |holdAddr_q;
                    rf_waddr   <= holdAddr_q;
                    rf_wdata   <= holdData_q;
                    holdAddr_q <= 5'd0;
                    holdData_q <= 32'd0;
                    waitCnt_q  <= 4'd0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Self-checking bench for wb_port_arbiter (STARVE_LIMIT = 3).
//
// A transaction-level model tracks:
//   - the parked MDU result, as a queue of at most one entry
//   - how many times that result has lost the port
//   - whether a forced write is due
// Every cycle, all DUT outputs are compared against this model.
//
// Directed scenarios also pin the outputs to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int LIMIT = 3;

    logic        clk;
    logic        rst;
    logic        pipe_wb_en;
    logic [4:0]  pipe_wb_addr;
    logic [31:0] pipe_wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wb_en   (pipe_wb_en),
        .pipe_wb_addr (pipe_wb_addr),
        .pipe_wb_data (pipe_wb_data),
        .mdu_valid    (mdu_valid),
        .mdu_addr     (mdu_addr),
        .mdu_data     (mdu_data),
        .mdu_ready    (mdu_ready),
        .pipe_stall   (pipe_stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } item_t;

    item_t       holdQ[$];
    int          losses;
    bit          forceDue;
    logic        mWe;
    logic [4:0]  mAddr;
    logic [31:0] mData;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Record a granted write. Register 0 is consumed without raising the enable.
    task automatic grant(input logic [4:0] a, input logic [31:0] d);
        mWe   = (a != 5'd0);
        mAddr = a;
        mData = d;
    endtask

    // Advance the model by one clock edge, using the inputs present at that edge.
    task automatic modelEdge();
        item_t it;
        bit    accept;
        mWe = 1'b0;
        if (!rst) begin
            holdQ.delete();
            losses   = 0;
            forceDue = 0;
            mAddr    = 5'd0;
            mData    = 32'd0;
        end else if (forceDue) begin
            it = holdQ.pop_front();
            grant(it.a, it.d);
            losses   = 0;
            forceDue = 0;
        end else begin
            accept = mdu_valid && (holdQ.size() == 0);
            if (holdQ.size() != 0) begin
                if (!pipe_wb_en) begin
                    it = holdQ.pop_front();
                    grant(it.a, it.d);
                    losses = 0;
                end else if (pipe_wb_addr == holdQ[0].a && pipe_wb_addr != 5'd0) begin
                    void'(holdQ.pop_front());
                    grant(pipe_wb_addr, pipe_wb_data);
                    losses = 0;
                end else begin
                    grant(pipe_wb_addr, pipe_wb_data);
                    losses++;
                    if (losses == LIMIT) forceDue = 1;
                end
            end else if (pipe_wb_en) begin
                grant(pipe_wb_addr, pipe_wb_data);
            end
            if (accept) begin
                it.a = mdu_addr;
                it.d = mdu_data;
                holdQ.push_back(it);
                losses = 0;
            end
        end
    endtask

    // Compare every DUT output against the model. Called at the falling edge.
    task automatic checkOutput();
        check("rf_we", 32'(rf_we), 32'(mWe));
        check("rf_waddr", 32'(rf_waddr), 32'(mAddr));
        check("rf_wdata", rf_wdata, mData);
        check("mdu_ready", 32'(mdu_ready), 32'(rst && holdQ.size() == 0));
        check("pipe_stall", 32'(pipe_stall), 32'(rst && forceDue));
    endtask

    // Drive one cycle of inputs, clock it, update the model, then compare.
    task automatic applyStimulus(input logic rv, input logic en, input logic [4:0] pa,
                                 input logic [31:0] pd, input logic mv,
                                 input logic [4:0] ma, input logic [31:0] md);
        rst          = rv;
        pipe_wb_en   = en;
        pipe_wb_addr = pa;
        pipe_wb_data = pd;
        mdu_valid    = mv;
        mdu_addr     = ma;
        mdu_data     = md;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        rst = 1'b0; pipe_wb_en = 1'b0; pipe_wb_addr = 5'd0; pipe_wb_data = 32'd0;
        mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
        holdQ.delete(); losses = 0; forceDue = 0;
        mWe = 1'b0; mAddr = 5'd0; mData = 32'd0;
        @(negedge clk);

        // Reset state
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h1111, 1'b1, 5'd4, 32'h2222);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("lit_reset_we", 32'(rf_we), 32'd0);
        check("lit_reset_addr", 32'(rf_waddr), 32'd0);
        check("lit_reset_data", rf_wdata, 32'd0);
        check("lit_reset_ready", 32'(mdu_ready), 32'd0);
        check("lit_reset_stall", 32'(pipe_stall), 32'd0);

        // Pipe only
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        check("lit_pipe_we", 32'(rf_we), 32'd1);
        check("lit_pipe_addr", 32'(rf_waddr), 32'd5);
        check("lit_pipe_data", rf_wdata, 32'hDEADBEEF);
        check("lit_pipe_stall", 32'(pipe_stall), 32'd0);

        // MDU result with the pipe idle: written two edges after acceptance
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678);
        check("lit_mdu_ready_low", 32'(mdu_ready), 32'd0);
        check("lit_mdu_we_early", 32'(rf_we), 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("lit_mdu_we", 32'(rf_we), 32'd1);
        check("lit_mdu_addr", 32'(rf_waddr), 32'd7);
        check("lit_mdu_data", rf_wdata, 32'h12345678);
        check("lit_mdu_ready_back", 32'(mdu_ready), 32'd1);

        // Starvation: three pipe grants, then one forced cycle
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(10 + i), 32'(32'hA0 + i), 1'b0, 5'd0, 32'h0);
            check("lit_starve_pipe_addr", 32'(rf_waddr), 32'(10 + i));
            check("lit_starve_stall", 32'(pipe_stall), (i == 2) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 5'd20, 32'hBAD, 1'b0, 5'd0, 32'h0);
        check("lit_force_addr", 32'(rf_waddr), 32'd3);
        check("lit_force_data", rf_wdata, 32'h33);
        check("lit_force_stall_off", 32'(pipe_stall), 32'd0);
        check("lit_force_ready", 32'(mdu_ready), 32'd1);

        // WAW drop: the pipe's write to the same register wins
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
        applyStimulus(1'b1, 1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 32'h0);
        check("lit_waw_data", rf_wdata, 32'hAA);
        check("lit_waw_ready", 32'(mdu_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("lit_waw_no_mdu_we", 32'(rf_we), 32'd0);
        check("lit_waw_no_mdu_data", rf_wdata, 32'hAA);

        // Register 0 from both sources
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
        check("lit_x0_pipe_we", 32'(rf_we), 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h66);
        check("lit_x0_mdu_accept", 32'(mdu_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("lit_x0_mdu_we", 32'(rf_we), 32'd0);
        check("lit_x0_ready", 32'(mdu_ready), 32'd1);

        // Reset while a result is parked
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h77);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("lit_rstpend_addr", 32'(rf_waddr), 32'd0);
        check("lit_rstpend_data", rf_wdata, 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("lit_rstpend_we", 32'(rf_we), 32'd0);
        check("lit_rstpend_ready", 32'(mdu_ready), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 49) != 0),
                          ($urandom_range(0, 9) < 7),
                          5'($urandom_range(0, 7)),
                          $urandom(),
                          1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)),
                          $urandom());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
